uart_rx_ctrl: RTL

Parametrised serial receiver controller. It is the successor to the fixed-format receiver control unit, and integrates the bit timer, start-bit validation, shift register, parity check and stop-bit check into a single block.
- Data width, stop-bit count, parity mode and oversampling rate are parameters.
- It sits between the line input pin and the receive buffer consumer, and reports framing, parity and overrun errors per frame.

---
 rtl/uart_rx_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - parametrised UART receiver controller with framing/parity/overrun reporting
// Optional UART_RX_SYNC_EN: adds a 2-flop input synchronizer ahead of edge detection.
module uart_rx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error,
    output logic                 busy
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, LOAD, ERROR} state_t;

    state_t               state;
    logic [TW-1:0]        timer;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 prev_line;
    logic                 frame_err;
    logic                 par_err;
    logic                 line;

`ifdef UART_RX_SYNC_EN
    logic sync_a;
    logic sync_b;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= serial_in;
            sync_b <= sync_a;
        end
    end

    assign line = sync_b;
`else
    assign line = serial_in;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            timer         <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            prev_line     <= 1'b1;
            frame_err     <= 1'b0;
            par_err       <= 1'b0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            prev_line <= line;
            // A read coinciding with LOAD is resolved inside the LOAD branch.
            if (data_read && state != LOAD) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (prev_line && !line) begin
                        timer     <= HALF_LOAD;
                        bit_cnt   <= '0;
                        frame_err <= 1'b0;
                        par_err   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START, DATA, PARITY, STOP: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        timer <= FULL_LOAD;
                        case (state)
                            START: begin
                                if (line) begin
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end else begin
                                    state <= DATA;
                                end
                            end
                            DATA: begin
                                shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
                                if (bit_cnt == LAST_DATA) begin
                                    bit_cnt <= '0;
                                    state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            PARITY: begin
                                par_err <= (^shift_reg) ^ line ^ ODD_PAR;
                                state   <= STOP;
                            end
                            default: begin
                                if (!line)
                                    frame_err <= 1'b1;
                                if (bit_cnt == LAST_STOP) begin
                                    bit_cnt <= '0;
                                    state   <= (frame_err || !line) ? ERROR : LOAD;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                LOAD: begin
                    rx_data       <= shift_reg;
                    data_ready    <= 1'b1;
                    parity_error  <= par_err;
                    framing_error <= 1'b0;
                    if (data_ready && !data_read)
                        overrun_error <= 1'b1;
                    else if (data_read)
                        overrun_error <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                ERROR: begin
                    framing_error <= 1'b1;
                    parity_error  <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
